signed_div_ctrl: RTL and testbench
==================================

// Module: signed_div_ctrl
// PURPOSE
//  Front/back end of the ALU division path; sits between ALU op dispatch and the unsigned sequential divider core.
//  Accepts signed or unsigned requests over valid/ready and screens divide-by-zero and MIN/-1 without using the core.
//  Launches the core on operand magnitudes with a one-cycle start pulse and waits for its done pulse.
//  Applies sign correction and holds the result until the consumer accepts it.
// PARAMETERS
//  WIDTH    16  operand/result width in bits
//  TIMEOUT  40  max cycles in WAIT for div_done before aborting; must be >= core latency + 2
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous, active-high reset
//  req_valid     in   1      request present
//  req_ready     out  1      block can accept (IDLE only)
//  req_signed    in   1      1 = two's-complement operation, 0 = unsigned
//  req_dividend  in   WIDTH  dividend
//  req_divisor   in   WIDTH  divisor
//  div_start     out  1      one-cycle launch pulse to core
//  div_dividend  out  WIDTH  registered magnitude; stable from LAUNCH until the core's done pulse
//  div_divisor   out  WIDTH  registered magnitude; same rule
//  div_quot      in   WIDTH  core quotient; sampled only with div_done
//  div_rem       in   WIDTH  core remainder; sampled only with div_done
//  div_done      in   1      core completion pulse
//  rsp_valid     out  1      result valid (HOLD)
//  rsp_ready     in   1      consumer accepts
//  rsp_quot      out  WIDTH  final quotient
//  rsp_rem       out  WIDTH  final remainder
//  rsp_dbz       out  1      divide-by-zero flag
//  rsp_ovf       out  1      signed overflow (MIN / -1) flag
//  rsp_timeout   out  1      core did not answer within TIMEOUT cycles
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready=1; wait counter 0.
//  Operation on a rising clk edge with rst high is ignored. Reset aborts any state, including WAIT and HOLD.
//  IDLE: req_ready=1. On req_valid&req_ready, register operands, mode, sign_q=sd^sv and sign_r=sd. sd/sv are the operand MSBs when signed, else 0.
//    - divisor==0: quot=all-ones, rem=dividend, dbz=1 -> HOLD.
//    - signed & dividend==MIN & divisor==all-ones: quot=MIN, rem=0, ovf=1 -> HOLD.
//    - otherwise: div_dividend/div_divisor <= magnitudes (MIN magnitude = 1<<(WIDTH-1)) -> LAUNCH.
//  LAUNCH: div_start=1 for exactly this one cycle, then WAIT with counter cleared.
//  WAIT: counter increments each cycle.
//    - On div_done, capture div_quot/div_rem and go to FIXUP.
//    - If the counter reaches TIMEOUT-1 without done: quot=rem=0, timeout=1 -> HOLD.
//    - div_done and the limit in the same cycle: done wins.
//  FIXUP: quot negated if sign_q; rem negated if sign_r. Negation is two's complement, modulo 2^WIDTH. Then HOLD.
//  HOLD: rsp_valid=1. rsp_* and flags stay stable until rsp_valid&rsp_ready, then IDLE.
//    - Flags cleared on leaving HOLD.
//    - A new request is not accepted in the same cycle as the handshake.
//  div_done outside WAIT (stale or spurious) is ignored. div_start is never asserted for the dbz/ovf bypasses.
//  Latency from accept edge to rsp_valid:
//    - bypass: 1 cycle.
//    - normal: 3 cycles + core cycles from start to done, i.e. LAUNCH, WAIT..., FIXUP, HOLD.
//  Throughput: at most one request in flight; req_ready=0 in LAUNCH/WAIT/FIXUP/HOLD.
//  Sign rules: quotient truncates toward zero; remainder takes the dividend's sign (-7/2 = -3 r -1; 7/-2 = -3 r 1).
// STRUCTURE
//  Shared include div_defs.vh holds:
//    - state encodings IDLE=0, LAUNCH=1, WAIT=2, FIXUP=3, HOLD=4 (3-bit);
//    - WIDTH default;
//    - MIN/all-ones constants as functions of WIDTH.
//  Sub-module div_sign_fix (combinational, WIDTH-parameterised):
//    - conditional two's-complement negate;
//    - used for magnitudes in IDLE and for the result fix-up.
//  The core is not instantiated here; the ALU top wires div_* ports to the divider and drives its reset from the same source.
// TESTING  (bench uses a stub core returning true unsigned quot/rem with div_done 17 cycles after div_start)
//  1 signed 0xFFF9 / 0x0002:
//      div_start high 1 cycle with operands 7,2 -> rsp_quot=0xFFFD, rsp_rem=0xFFFF, flags 0.
//  2 unsigned 0xFFFF / 0x0010 -> div_dividend=0xFFFF, rsp_quot=0x0FFF, rsp_rem=0x000F; signed 0x0007 / 0xFFFE -> quot 0xFFFD, rem 0x0001.
//  3 divisor 0, dividend 0x1234 (either mode):
//      rsp_valid 1 cycle after accept, quot=0xFFFF, rem=0x1234, dbz=1, div_start never high.
//  4 signed 0x8000 / 0xFFFF -> quot=0x8000, rem=0x0000, ovf=1, no div_start.
//      Signed 0x8000 / 0x0001 -> magnitude 0x8000 sent, quot=0x8000.
//  5 backpressure: rsp_ready low 5 cycles -> rsp_* stable, req_ready=0, a held req_valid not accepted; accepted 1 cycle after the handshake cycle.
//  6 stub never sends done:
//      -> rsp_timeout=1 exactly TIMEOUT cycles after LAUNCH, quot=rem=0.
//      rst pulsed mid-WAIT -> next cycle rsp_valid=0, req_ready=1; a late div_done is ignored.

Source files
------------

// File: rtl/signed_div_ctrl_pkg.sv
// Shared types and constants for the signed division controller.
package signed_div_ctrl_pkg;

  localparam int DIV_W  = 16;
  localparam int DIV_TO = 40;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_FIXUP  = 3'd3,
    ST_HOLD   = 3'd4
  } div_state_e;

  // Most negative two's-complement value for a given width.
  function automatic logic [63:0] div_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, modulo 2^WIDTH.
module div_sign_fix #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/signed_div_ctrl.sv
// Signed/unsigned front and back end around an unsigned sequential divider.
import signed_div_ctrl_pkg::*;

module signed_div_ctrl #(
  parameter int WIDTH   = DIV_W,
  parameter int TIMEOUT = DIV_TO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  input  logic             div_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quot,
  output logic [WIDTH-1:0] rsp_rem,
  output logic             rsp_dbz,
  output logic             rsp_ovf,
  output logic             rsp_timeout
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [WIDTH-1:0] MIN  = WIDTH'(div_min(WIDTH));
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [CW-1:0]    LIM  = CW'(TIMEOUT - 1);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;
  logic             r_ovf;
  logic             r_to;

  logic             w_sd;
  logic             w_sv;
  logic             w_is_dbz;
  logic             w_is_ovf;
  logic             w_limit;
  logic [WIDTH-1:0] w_mag_dvd;
  logic [WIDTH-1:0] w_mag_dvs;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;

  assign w_sd      = req_signed & req_dividend[WIDTH-1];
  assign w_sv      = req_signed & req_divisor[WIDTH-1];
  assign w_is_dbz  = (req_divisor == '0);
  assign w_is_ovf  = req_signed &&
                     (req_dividend == MIN) &&
                     (req_divisor == ONES);
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_limit   = (w_cnt_nxt == LIM);

  div_sign_fix #(.WIDTH(WIDTH)) u_mag_dvd (
    .i_val(req_dividend),
    .i_neg(w_sd),
    .o_val(w_mag_dvd)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_mag_dvs (
    .i_val(req_divisor),
    .i_neg(w_sv),
    .o_val(w_mag_dvs)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .i_val(r_quot),
    .i_neg(r_sign_q),
    .o_val(w_fix_q)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .i_val(r_rem),
    .i_neg(r_sign_r),
    .o_val(w_fix_r)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            w_is_dbz: w_state_nxt = ST_HOLD;
            w_is_ovf: w_state_nxt = ST_HOLD;
            default:  w_state_nxt = ST_LAUNCH;
          endcase
        end
      end
      ST_LAUNCH: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // A done pulse on the limit cycle still delivers the result.
        if (div_done)
          w_state_nxt = ST_FIXUP;
        else if (w_limit)
          w_state_nxt = ST_HOLD;
      end
      ST_FIXUP: w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (rsp_ready)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_sign_q <= w_sd ^ w_sv;
            r_sign_r <= w_sd;
            if (w_is_dbz) begin
              r_quot <= ONES;
              r_rem  <= req_dividend;
              r_dbz  <= 1'b1;
            end else if (w_is_ovf) begin
              r_quot <= MIN;
              r_rem  <= '0;
              r_ovf  <= 1'b1;
            end else begin
              r_dvd <= w_mag_dvd;
              r_dvs <= w_mag_dvs;
            end
          end
        end
        ST_LAUNCH: r_cnt <= '0;
        ST_WAIT: begin
          r_cnt <= w_cnt_nxt;
          if (div_done) begin
            r_quot <= div_quot;
            r_rem  <= div_rem;
          end else if (w_limit) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_to   <= 1'b1;
          end
        end
        ST_FIXUP: begin
          r_quot <= w_fix_q;
          r_rem  <= w_fix_r;
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
            r_to  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign div_start    = (r_state == ST_LAUNCH);
  assign rsp_valid    = (r_state == ST_HOLD);
  assign div_dividend = r_dvd;
  assign div_divisor  = r_dvs;
  assign rsp_quot     = r_quot;
  assign rsp_rem      = r_rem;
  assign rsp_dbz      = r_dbz;
  assign rsp_ovf      = r_ovf;
  assign rsp_timeout  = r_to;

endmodule

// File: tb/tb_signed_div_ctrl.sv
// Self-checking bench for signed_div_ctrl with a 17-cycle stub divider core.
module tb_signed_div_ctrl;

  localparam int W    = 16;
  localparam int TO   = 40;
  localparam int CORE = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_signed;
  logic [W-1:0]  req_dividend;
  logic [W-1:0]  req_divisor;
  logic          div_start;
  logic [W-1:0]  div_dividend;
  logic [W-1:0]  div_divisor;
  logic [W-1:0]  div_quot;
  logic [W-1:0]  div_rem;
  logic          div_done;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_quot;
  logic [W-1:0]  rsp_rem;
  logic          rsp_dbz;
  logic          rsp_ovf;
  logic          rsp_timeout;

  int errors = 0;
  int checks = 0;

  bit            stub_en;
  bit            spur_done;
  int            st_cnt;
  logic [W-1:0]  sa;
  logic [W-1:0]  sb;

  always #5 clk = ~clk;

  signed_div_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_signed(req_signed),
    .req_dividend(req_dividend),
    .req_divisor(req_divisor),
    .div_start(div_start),
    .div_dividend(div_dividend),
    .div_divisor(div_divisor),
    .div_quot(div_quot),
    .div_rem(div_rem),
    .div_done(div_done),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_quot(rsp_quot),
    .rsp_rem(rsp_rem),
    .rsp_dbz(rsp_dbz),
    .rsp_ovf(rsp_ovf),
    .rsp_timeout(rsp_timeout)
  );

  // stub core: done is high CORE cycles after the cycle div_start was high
  always @(posedge clk) begin
    if (rst) begin
      st_cnt <= 0;
      sa     <= '0;
      sb     <= '0;
    end else if (div_start && stub_en) begin
      st_cnt <= 1;
      sa     <= div_dividend;
      sb     <= div_divisor;
    end else if (st_cnt == CORE) begin
      st_cnt <= 0;
    end else if (st_cnt != 0) begin
      st_cnt <= st_cnt + 1;
    end
  end

  assign div_done = (st_cnt == CORE) || spur_done;
  assign div_quot = (sb != 0) ? sa / sb : 16'hDEAD;
  assign div_rem  = (sb != 0) ? sa % sb : 16'hBEEF;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mag(input bit sg, input logic [W-1:0] x);
    if (sg && x[W-1]) return ~x + 16'd1;
    return x;
  endfunction

  // reference: plain integer division with the architectural special cases
  function automatic void model(input bit sg, input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] q,
                                output logic [W-1:0] r,
                                output bit dbz, output bit ovf);
    int ia;
    int ib;
    dbz = 0;
    ovf = 0;
    if (b == 0) begin
      q = 16'hFFFF; r = a; dbz = 1;
    end else if (sg && a == 16'h8000 && b == 16'hFFFF) begin
      q = 16'h8000; r = 16'h0000; ovf = 1;
    end else if (sg) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
      q = 16'(ia / ib);
      r = 16'(ia % ib);
    end else begin
      ia = int'(a);
      ib = int'(b);
      q = 16'(ia / ib);
      r = 16'(ia % ib);
    end
  endfunction

  task automatic do_req(input bit sg, input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dbz, output logic ovf,
                        output logic to, output int lat, output int nst,
                        output logic [W-1:0] ma, output logic [W-1:0] mb);
    nst = 0;
    ma  = '0;
    mb  = '0;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_signed   = sg;
    req_dividend = a;
    req_divisor  = b;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      if (div_start) begin
        nst++;
        ma = div_dividend;
        mb = div_divisor;
      end
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_wait_bound", 32'(lat), 32'd0);
    q   = rsp_quot;
    r   = rsp_rem;
    dbz = rsp_dbz;
    ovf = rsp_ovf;
    to  = rsp_timeout;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input bit sg,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r, eq, er, ma, mb;
    logic dbz, ovf, to;
    bit   edbz, eovf, byp;
    int   lat, nst;
    model(sg, a, b, eq, er, edbz, eovf);
    byp = edbz || eovf;
    do_req(sg, a, b, q, r, dbz, ovf, to, lat, nst, ma, mb);
    chk({tag, "_quot"}, 32'(q), 32'(eq));
    chk({tag, "_rem"}, 32'(r), 32'(er));
    chk({tag, "_dbz"}, 32'(dbz), 32'(edbz));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    chk({tag, "_timeout"}, 32'(to), 32'd0);
    chk({tag, "_latency"}, 32'(lat), byp ? 32'd1 : 32'(3 + CORE));
    chk({tag, "_starts"}, 32'(nst), byp ? 32'd0 : 32'd1);
    if (!byp) begin
      chk({tag, "_mag_dvd"}, 32'(ma), 32'(mag(sg, a)));
      chk({tag, "_mag_dvs"}, 32'(mb), 32'(mag(sg, b)));
    end
  endtask

  typedef struct {
    bit           sg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    bit           dbz;
    bit           ovf;
  } vec_t;

  initial begin
    vec_t vt[10];
    logic [W-1:0] q, r, ma, mb, ra, rb;
    logic dbz, ovf, to;
    int   lat, nst, n;
    bit   rsg;

    vt[0] = '{1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 0, 0};
    vt[1] = '{0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 0, 0};
    vt[2] = '{1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 0, 0};
    vt[3] = '{1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, 0};
    vt[4] = '{0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, 0};
    vt[5] = '{1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 0, 1};
    vt[6] = '{1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 0, 0};
    vt[7] = '{0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 0, 0};
    vt[8] = '{1, 16'h0007, 16'h0002, 16'h0003, 16'h0001, 0, 0};
    vt[9] = '{1, 16'hFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 0, 0};

    rst = 1'b1;
    req_valid = 1'b0;
    req_signed = 1'b0;
    req_dividend = '0;
    req_divisor = '0;
    rsp_ready = 1'b0;
    stub_en = 1'b1;
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_outputs", {rsp_quot, rsp_rem}, 32'd0);
    chk("rst_flags", {29'd0, rsp_dbz, rsp_ovf, rsp_timeout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed table
    for (int i = 0; i < 10; i++) begin
      do_req(vt[i].sg, vt[i].a, vt[i].b, q, r, dbz, ovf, to, lat, nst,
             ma, mb);
      chk($sformatf("vec%0d_quot", i), 32'(q), 32'(vt[i].q));
      chk($sformatf("vec%0d_rem", i), 32'(r), 32'(vt[i].r));
      chk($sformatf("vec%0d_flags", i), {30'd0, dbz, ovf},
          {30'd0, vt[i].dbz, vt[i].ovf});
      chk($sformatf("vec%0d_timeout", i), 32'(to), 32'd0);
      chk($sformatf("vec%0d_latency", i), 32'(lat),
          (vt[i].dbz || vt[i].ovf) ? 32'd1 : 32'(3 + CORE));
      chk($sformatf("vec%0d_starts", i), 32'(nst),
          (vt[i].dbz || vt[i].ovf) ? 32'd0 : 32'd1);
      if (!(vt[i].dbz || vt[i].ovf)) begin
        chk($sformatf("vec%0d_mag_dvd", i), 32'(ma),
            32'(mag(vt[i].sg, vt[i].a)));
        chk($sformatf("vec%0d_mag_dvs", i), 32'(mb),
            32'(mag(vt[i].sg, vt[i].b)));
      end
    end

    // randomized against the model, biased toward corner operands
    for (int i = 0; i < 120; i++) begin
      rsg = 1'($urandom_range(0, 1));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'h0000;
        1: begin ra = 16'h8000; rb = 16'hFFFF; end
        2: rb = 16'($urandom_range(1, 9));
        3: ra = 16'h8000;
        default: ;
      endcase
      run_check($sformatf("rnd%0d", i), rsg, ra, rb);
    end

    // backpressure: held result, blocked request, no accept on handshake
    req_valid = 1'b1;
    req_signed = 1'b1;
    req_dividend = 16'h0064;
    req_divisor = 16'h0007;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_hold", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1;
    req_signed = 1'b0;
    req_dividend = 16'h55AA;
    req_divisor = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_quot_c%0d", k), 32'(rsp_quot), 32'h000E);
      chk($sformatf("bp_rem_c%0d", k), 32'(rsp_rem), 32'h0002);
      chk($sformatf("bp_valid_c%0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_req_ready_c%0d", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp_no_start_c%0d", k), 32'(div_start), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_after_hs_valid", 32'(rsp_valid), 32'd0);
    chk("bp_after_hs_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_next_valid", 32'(rsp_valid), 32'd1);
    chk("bp_next_dbz", 32'(rsp_dbz), 32'd1);
    chk("bp_next_result", {rsp_quot, rsp_rem}, 32'hFFFF55AA);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // core never answers: timeout TO cycles after the launch cycle
    stub_en = 1'b0;
    req_valid = 1'b1;
    req_signed = 1'b1;
    req_dividend = 16'h0100;
    req_divisor = 16'h0003;
    @(negedge clk);
    req_valid = 1'b0;
    chk("to_launch", 32'(div_start), 32'd1);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'(TO));
    chk("to_flag", 32'(rsp_timeout), 32'd1);
    chk("to_result", {rsp_quot, rsp_rem}, 32'd0);
    chk("to_other_flags", {30'd0, rsp_dbz, rsp_ovf}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("to_flag_cleared", 32'(rsp_timeout), 32'd0);

    // reset mid-WAIT, then a late done must be ignored
    req_valid = 1'b1;
    req_dividend = 16'h0200;
    req_divisor = 16'h0005;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_valid", 32'(rsp_valid), 32'd0);
    chk("rstw_ready", 32'(req_ready), 32'd1);
    chk("rstw_start", 32'(div_start), 32'd0);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("late_done_valid_c%0d", k), 32'(rsp_valid), 32'd0);
      chk($sformatf("late_done_ready_c%0d", k), 32'(req_ready), 32'd1);
      @(negedge clk);
    end
    stub_en = 1'b1;
    run_check("recover", 1'b1, 16'hFF38, 16'h0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
